// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and pipeline stall.
// Optional MULDIV_EARLY_TERM_EN: multiply leaves RUN once remaining multiplier bits are zero.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdstart,
  input  logic [1:0]  mdop,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        mtwrite,
  input  logic        hilosrc,
  input  logic [1:0]  hilodisable,
  input  logic        hiloread,
  input  logic        hilosel,
  output logic [31:0] hiloout,
  output logic        mdbusy,
  output logic        mdstall
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [63:0] acc;
  logic [63:0] aux;
  logic [31:0] mplier;
  logic [31:0] a_raw;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        is_mul;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] mul_next;
  logic [32:0] rsh;
  logic [32:0] trial;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic        div0;
  logic        early;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    a_mag = (mdop[1] && srca[31]) ? 32'd0 - srca : srca;
    b_mag = (mdop[1] && srcb[31]) ? 32'd0 - srcb : srcb;
  end

  // Multiplicand in aux shifts left; multiplier in mplier shifts right.
  assign mul_next = mplier[0] ? acc + aux : acc;

  // Restoring divide: {R,Q} shifts left, trial-subtract into R.
  assign rsh      = acc[63:31];
  assign trial    = rsh - {1'b0, aux[31:0]};
  assign div_next = trial[32] ? {rsh[31:0], acc[30:0], 1'b0}
                              : {trial[31:0], acc[30:0], 1'b1};

  assign prod_fix = neg_q ? 64'd0 - acc : acc;
  assign q_fix    = neg_q ? 32'd0 - acc[31:0] : acc[31:0];
  assign r_fix    = neg_r ? 32'd0 - acc[63:32] : acc[63:32];
  assign div0     = (aux[31:0] == 32'd0);

  always_comb begin
    res_hi = prod_fix[63:32];
    res_lo = prod_fix[31:0];
    if (!is_mul) begin
      res_hi = div0 ? a_raw : r_fix;
      res_lo = div0 ? 32'hFFFF_FFFF : q_fix;
    end
  end

`ifdef MULDIV_EARLY_TERM_EN
  assign early = is_mul && (mplier[31:1] == 31'd0);
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= 5'd0;
      acc    <= 64'd0;
      aux    <= 64'd0;
      mplier <= 32'd0;
      a_raw  <= 32'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      is_mul <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mdstart && hilosrc) begin
            state  <= RUN;
            count  <= 5'd0;
            is_mul <= mdop[0];
            a_raw  <= srca;
            neg_q  <= mdop[1] & (srca[31] ^ srcb[31]);
            neg_r  <= mdop[1] & srca[31];
            mplier <= b_mag;
            if (mdop[0]) begin
              acc <= 64'd0;
              aux <= {32'd0, a_mag};
            end else begin
              acc <= {32'd0, a_mag};
              aux <= {32'd0, b_mag};
            end
          end else if (mtwrite && !hilosrc) begin
            if (!hilodisable[1]) hi <= srca;
            if (!hilodisable[0]) lo <= srca;
          end
        end
        RUN: begin
          count <= count + 5'd1;
          if (is_mul) begin
            acc    <= mul_next;
            aux    <= aux << 1;
            mplier <= mplier >> 1;
          end else begin
            acc <= div_next;
          end
          if (count == 5'd31 || early) state <= FIXUP;
        end
        FIXUP: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hiloout = hilosel ? hi : lo;
  assign mdbusy  = (state != IDLE);
  assign mdstall = mdbusy & (hiloread | mdstart | mtwrite);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed/scoreboard bench for mul_div_unit.
// Honors MULDIV_EARLY_TERM_EN for expected busy length.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdstart;
  logic [1:0]  mdop;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        mtwrite;
  logic        hilosrc;
  logic [1:0]  hilodisable;
  logic        hiloread;
  logic        hilosel;
  logic [31:0] hiloout;
  logic        mdbusy;
  logic        mdstall;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb_q[$];
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .mdstart(mdstart), .mdop(mdop),
    .srca(srca), .srcb(srcb), .mtwrite(mtwrite), .hilosrc(hilosrc),
    .hilodisable(hilodisable), .hiloread(hiloread), .hilosel(hilosel),
    .hiloout(hiloout), .mdbusy(mdbusy), .mdstall(mdstall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sa;
    int              sb;
    int              q;
    int              r;
    sa = int'(a);
    sb = int'(b);
    if (op == 2'b11) begin
      sp = longint'(sa) * longint'(sb);
      return sp;
    end
    if (op == 2'b01) begin
      up = {32'd0, a} * {32'd0, b};
      return up;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == 2'b10) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return {32'd0, 32'h8000_0000};
      q = sa / sb;
      r = sa % sb;
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  function automatic int exp_busy(input logic [1:0] op,
                                  input logic [31:0] b);
`ifdef MULDIV_EARLY_TERM_EN
    logic [31:0] m;
    int n;
    if (op[0]) begin
      m = (op[1] && b[31]) ? 32'd0 - b : b;
      n = 0;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      if (n == 0) n = 1;
      return n + 1;
    end
`endif
    return 33;
  endfunction

  task automatic check_result(input string tag);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    hilosel = 1'b1;
    #1 chk({tag, "_hi"}, hiloout, e[63:32]);
    hilosel = 1'b0;
    #1 chk({tag, "_lo"}, hiloout, e[31:0]);
    last_hi = e[63:32];
    last_lo = e[31:0];
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
    int n;
    int eb;
    logic [63:0] e;
    e  = model(op, a, b);
    eb = exp_busy(op, b);
    mdstart = 1'b1;
    hilosrc = 1'b1;
    mdop    = op;
    srca    = a;
    srcb    = b;
    sb_q.push_back(e);
    tick();
    mdstart = 1'b0;
    hilosrc = 1'b0;
    n = 0;
    while (mdbusy && n < 200) begin
      n++;
      if (inject) begin
        if (n == 2) hiloread = 1'b1;
        if (n >= 3 && n <= 5) begin
          mtwrite = 1'b1; hilosrc = 1'b0; srca = 32'd99;
        end
        if (n >= 6 && n <= 8) begin
          mtwrite = 1'b0; mdstart = 1'b1; hilosrc = 1'b1;
          mdop = 2'b01; srca = 32'd1; srcb = 32'd1;
        end
        if (n == 9) begin
          mdstart = 1'b0; mtwrite = 1'b0; hilosrc = 1'b0;
        end
        #1;
        if (n >= 2) chk({tag, "_stall"}, {31'd0, mdstall}, 32'd1);
        #1;
      end
      tick();
    end
    chk({tag, "_busy_len"}, n, eb);
    if (inject) begin
      hilosel = 1'b0;
      #1 chk({tag, "_mflo"}, hiloout, e[31:0]);
      chk({tag, "_nostall"}, {31'd0, mdstall}, 32'd0);
      hiloread = 1'b0;
    end
    check_result(tag);
  endtask

  initial begin
    reset = 1'b1; mdstart = 1'b0; mdop = 2'b00; srca = 32'd0;
    srcb = 32'd0; mtwrite = 1'b0; hilosrc = 1'b0; hilodisable = 2'b00;
    hiloread = 1'b0; hilosel = 1'b0;
    last_hi = 32'd0; last_lo = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    hiloread = 1'b1;
    hilosel = 1'b1;
    #1 chk("rst_hi", hiloout, 32'd0);
    hilosel = 1'b0;
    #1 chk("rst_lo", hiloout, 32'd0);
    chk("rst_busy", {31'd0, mdbusy}, 32'd0);
    chk("rst_stall", {31'd0, mdstall}, 32'd0);
    hiloread = 1'b0;
    tick();

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu_max_hi_k", last_hi, 32'hFFFF_FFFE);
    chk("multu_max_lo_k", last_lo, 32'h0000_0001);
    run_op("mult_m7x6", 2'b11, -32'sd7, 32'd6, 0);
    chk("mult_lo_k", last_lo, 32'hFFFF_FFD6);
    run_op("div_m7d2", 2'b10, -32'sd7, 32'd2, 0);
    chk("div_lo_k", last_lo, 32'hFFFF_FFFD);
    chk("div_hi_k", last_hi, 32'hFFFF_FFFF);
    run_op("divu_by0", 2'b00, 32'd100, 32'd0, 0);
    chk("divu0_hi_k", last_hi, 32'd100);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("ovf_lo_k", last_lo, 32'h8000_0000);
    run_op("div_by0_s", 2'b10, -32'sd5, 32'd0, 0);
    run_op("mult_stall", 2'b11, 32'd123, -32'sh1234_5678, 1);
    tick();
    chk("second_start_ignored", {31'd0, mdbusy}, 32'd0);

    mtwrite = 1'b1; hilosrc = 1'b0; srca = 32'd5; hilodisable = 2'b01;
    tick();
    mtwrite = 1'b0; hilodisable = 2'b00;
    hilosel = 1'b1;
    #1 chk("mthi_hi", hiloout, 32'd5);
    hilosel = 1'b0;
    #1 chk("mthi_lo_kept", hiloout, last_lo);
    mtwrite = 1'b1; srca = 32'd77; hilodisable = 2'b10;
    tick();
    mtwrite = 1'b0; hilodisable = 2'b00;
    #1 chk("mtlo_lo", hiloout, 32'd77);
    hilosel = 1'b1;
    #1 chk("mtlo_hi_kept", hiloout, 32'd5);

    run_op("multu_3x2", 2'b01, 32'd3, 32'd2, 0);
    run_op("mult_by1", 2'b11, -32'sd9, 32'd1, 0);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : $urandom_range(0, 300);
      run_op("rand", 2'(i), ra, rb, 0);
    end

    mdstart = 1'b1; hilosrc = 1'b1; mdop = 2'b00;
    srca = 32'd1000; srcb = 32'd7;
    tick();
    mdstart = 1'b0; hilosrc = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("pre_reset_busy", {31'd0, mdbusy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_busy", {31'd0, mdbusy}, 32'd0);
    hilosel = 1'b1;
    #1 chk("mid_reset_hi", hiloout, 32'd0);
    hilosel = 1'b0;
    #1 chk("mid_reset_lo", hiloout, 32'd0);
    tick();
    chk("post_reset_idle", {31'd0, mdbusy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
